// File: rtl/arashi_pkg.sv
// ============================================================================
// Module : arashi_pkg
// Brief  : Shared types and constants for the arashi drain controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package arashi_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } drain_state_e;

  localparam int ARASHI_DRAIN_SKID_DEPTH = 2;
  localparam int ARASHI_DRAIN_SKID_CNT_W = $clog2(ARASHI_DRAIN_SKID_DEPTH + 1);

  // Headroom of one late write burst from every thread after stall rises.
  function automatic int arashi_stall_threshold(input int depth, input int thread_num);
    return depth - 2 * thread_num;
  endfunction

endpackage : arashi_pkg

`default_nettype wire

// File: rtl/arashi_skid2.sv
// ============================================================================
// Module : arashi_skid2
// Brief  : Two-entry FIFO holding read data returned from the thread memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module arashi_skid2
  import arashi_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               i_push,
  input  logic                               i_pop,
  input  logic [DATA_WIDTH-1:0]              i_data,
  output logic [ARASHI_DRAIN_SKID_CNT_W-1:0] o_count,
  output logic [DATA_WIDTH-1:0]              o_head
);

  localparam int CW = ARASHI_DRAIN_SKID_CNT_W;

  logic [DATA_WIDTH-1:0] r_mem [ARASHI_DRAIN_SKID_DEPTH];
  logic                  r_wr_idx;
  logic                  r_rd_idx;
  logic [CW-1:0]         r_count;
  logic                  w_push;
  logic                  w_pop;

  // Protect the pointers against a push into a full buffer or a pop from empty.
  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != CW'(ARASHI_DRAIN_SKID_DEPTH)) || w_pop);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wr_idx <= 1'b0;
      r_rd_idx <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_idx] <= i_data;
        r_wr_idx        <= ~r_wr_idx;
      end
      if (w_pop) begin
        r_rd_idx <= ~r_rd_idx;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_idx];

endmodule : arashi_skid2

`default_nettype wire

// File: rtl/arashi_drain_ctrl.sv
// ============================================================================
// Module : arashi_drain_ctrl
// Brief  : Read-side controller of the shared thread write memory: in-order
//          valid/ready delivery, registered thread stall, flush-and-drain.
//          Optional overflow check enabled by ARASHI_DRAIN_OVF_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module arashi_drain_ctrl
  import arashi_pkg::*;
#(
  parameter int THREAD_NUM = 4,
  parameter int MEM_WIDTH  = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [$clog2(THREAD_NUM+1)-1:0] wr_cnt,
  output logic                            stall,
  output logic                            rd_en,
  output logic [MEM_WIDTH-1:0]            rd_addr,
  input  logic [DATA_WIDTH-1:0]           rd_data,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  input  logic                            out_ready,
  input  logic                            flush,
  output logic                            flush_done,
  output logic [MEM_WIDTH:0]              level,
  output logic                            ovf
);

  localparam int DEPTH   = 2 ** MEM_WIDTH;
  localparam int PTR_W   = MEM_WIDTH + 1;
  localparam int SKID_CW = ARASHI_DRAIN_SKID_CNT_W;
  localparam logic [PTR_W-1:0] STALL_TH = PTR_W'(arashi_stall_threshold(DEPTH, THREAD_NUM));

  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [PTR_W-1:0]      w_wptr_next;
  logic [PTR_W-1:0]      w_rptr_next;
  logic [PTR_W-1:0]      w_wr_ext;
  logic [PTR_W-1:0]      w_level;
  logic [PTR_W-1:0]      w_level_next;
  logic                  w_level_hi;
  logic                  r_inflight;
  logic                  w_rd_en;
  logic [SKID_CW-1:0]    w_skid_cnt;
  logic [SKID_CW-1:0]    w_held;
  logic [DATA_WIDTH-1:0] w_skid_head;
  logic                  w_skid_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_drained;
  drain_state_e          r_state;
  logic                  r_stall;
  logic                  r_flush_done;

  assign w_wr_ext = PTR_W'(wr_cnt);
  assign w_level  = r_wptr - r_rptr;

  // Entries already committed to the output side: buffered plus the one in flight.
  assign w_held  = w_skid_cnt + SKID_CW'(r_inflight);
  assign w_rd_en = (w_level != '0) && (w_held < SKID_CW'(ARASHI_DRAIN_SKID_DEPTH));

  assign w_rptr_next = r_rptr + PTR_W'(w_rd_en);

`ifdef ARASHI_DRAIN_OVF_CHECK_EN
  logic             r_ovf;
  logic [PTR_W:0]   w_fill;
  logic             w_ovf_hit;

  assign w_fill      = {1'b0, w_level} + {1'b0, w_wr_ext};
  assign w_ovf_hit   = w_fill > (PTR_W + 1)'(DEPTH);
  // A burst that would overrun unread entries is dropped as a whole.
  assign w_wptr_next = w_ovf_hit ? r_wptr : (r_wptr + w_wr_ext);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_hit) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;

  a_no_overflow : assert property (@(posedge clk) disable iff (!rstn) !w_ovf_hit);
`else
  assign w_wptr_next = r_wptr + w_wr_ext;
  assign ovf         = 1'b0;
`endif

  assign w_level_next = w_wptr_next - w_rptr_next;
  assign w_level_hi   = w_level_next > STALL_TH;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_wptr     <= w_wptr_next;
      r_rptr     <= w_rptr_next;
      r_inflight <= w_rd_en;
    end
  end

  // Returning data bypasses the skid buffer when it is empty and the consumer is ready.
  assign w_skid_empty = (w_skid_cnt == '0);
  assign w_pop        = !w_skid_empty && out_ready;
  assign w_push       = r_inflight && !(w_skid_empty && out_ready);

  arashi_skid2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (rd_data),
    .o_count (w_skid_cnt),
    .o_head  (w_skid_head)
  );

  assign w_drained = (w_level == '0) && !r_inflight && w_skid_empty;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= RUN;
      r_stall      <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_stall      <= w_level_hi;
      r_flush_done <= 1'b0;
      case (r_state)
        RUN: begin
          if (flush) begin
            r_state <= FLUSH;
            r_stall <= 1'b1;
          end
        end
        FLUSH: begin
          r_stall <= 1'b1;
          if (w_drained) begin
            r_state      <= DONE;
            r_flush_done <= 1'b1;
          end
        end
        DONE: begin
          r_state <= RUN;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign stall      = r_stall;
  assign flush_done = r_flush_done;
  assign rd_en      = w_rd_en;
  assign rd_addr    = r_rptr[MEM_WIDTH-1:0];
  assign level      = w_level;
  assign out_valid  = !w_skid_empty || r_inflight;
  assign out_data   = w_skid_empty ? rd_data : w_skid_head;

endmodule : arashi_drain_ctrl

`default_nettype wire
